// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state, grant owner and
// request type encodings.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWNER_IMEM = 1'b0,
        OWNER_DMEM = 1'b1
    } owner_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWNER_IMEM) ? OWNER_DMEM : OWNER_IMEM;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// side that was not granted last.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic   ival,
    input  logic   dval,
    input  owner_t last_grant,
    output owner_t winner,
    output logic   any
);

    always_comb begin
        any    = ival | dval;
        winner = OWNER_IMEM;
        if (ival && dval)
            winner = other_owner(last_grant);
        else if (dval)
            winner = OWNER_DMEM;
    end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates instruction-fetch and data ports onto one shared memory port,
// one transaction outstanding at a time, round-robin on ties.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imemreq_val,
    output logic              imemreq_rdy,
    input  logic [ADDR_W-1:0] imemreq_addr,
    output logic              imemresp_val,
    output logic [DATA_W-1:0] imemresp_data,
    input  logic              dmemreq_val,
    output logic              dmemreq_rdy,
    input  logic              dmemreq_type,
    input  logic [ADDR_W-1:0] dmemreq_addr,
    input  logic [DATA_W-1:0] dmemreq_wdata,
    output logic              dmemresp_val,
    output logic [DATA_W-1:0] dmemresp_rdata,
    output logic              memreq_val,
    input  logic              memreq_rdy,
    output logic              memreq_type,
    output logic [ADDR_W-1:0] memreq_addr,
    output logic [DATA_W-1:0] memreq_wdata,
    input  logic              memresp_val,
    input  logic [DATA_W-1:0] memresp_data,
    output logic              err
);

    state_t state;
    owner_t owner;
    owner_t last_grant;
    owner_t winner;
    logic   any;
    logic   issue;
    logic   fire;
    logic   resp_hit;

    mem_arb_rr_pick u_pick (
        .ival       (imemreq_val),
        .dval       (dmemreq_val),
        .last_grant (last_grant),
        .winner     (winner),
        .any        (any)
    );

    // Reset gates every handshake output so they drop the moment rst falls,
    // not at the next edge.
    assign issue    = rst && (state == IDLE) && any;
    assign fire     = issue && memreq_rdy;
    assign resp_hit = rst && (state == BUSY) && memresp_val;

    always_comb begin
        memreq_val   = issue;
        memreq_type  = MEM_READ;
        memreq_addr  = '0;
        memreq_wdata = '0;
        if (issue) begin
            if (winner == OWNER_DMEM) begin
                memreq_type  = dmemreq_type;
                memreq_addr  = dmemreq_addr;
                memreq_wdata = dmemreq_wdata;
            end else begin
                memreq_addr  = imemreq_addr;
            end
        end
    end

    assign imemreq_rdy = fire && (winner == OWNER_IMEM);
    assign dmemreq_rdy = fire && (winner == OWNER_DMEM);

    assign imemresp_val   = resp_hit && (owner == OWNER_IMEM);
    assign dmemresp_val   = resp_hit && (owner == OWNER_DMEM);
    assign imemresp_data  = imemresp_val ? memresp_data : '0;
    assign dmemresp_rdata = dmemresp_val ? memresp_data : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWNER_IMEM;
            last_grant <= OWNER_DMEM;
            err        <= 1'b0;
        end else begin
            // A response with nothing outstanding is dropped but remembered.
            if (state == IDLE && memresp_val)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (fire) begin
                        state      <= BUSY;
                        owner      <= winner;
                        last_grant <= winner;
                    end
                end
                BUSY: begin
                    if (memresp_val)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
